// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, hides the 1-cycle imem read latency, handles stall/redirect/flush/halt.
// Optional IFETCH_PERF_EN adds saturating FetchCount/StallCount outputs.
module instruction_fetch_unit #(
    parameter int          RESET_PC   = 0,
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] HALT_WORD  = 32'hffffffff
) (
    input  logic        Clk,
    input  logic        Rst,
    output logic [31:0] ImemRdAddr,
    input  logic [31:0] ImemRdData,
    input  logic        Stall,
    input  logic        Redirect,
    input  logic [31:0] RedirectAddr,
    input  logic        Flush,
    output logic [31:0] IfPc,
    output logic [31:0] IfInstr,
    output logic        IfValid,
    output logic        Halted,
`ifdef IFETCH_PERF_EN
    output logic [31:0] FetchCount,
    output logic [31:0] StallCount,
`endif
    output logic [1:0]  DbgState
);
    localparam int             AW     = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam logic [AW-1:0]  RST_PC = AW'(RESET_PC);

    typedef enum logic [1:0] {S_WAIT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

    state_t        state_q;
    logic [AW-1:0] pc_q;
    logic [AW-1:0] fpc_q;
    logic          fvld_q;
    logic          halted_q;
    logic [AW-1:0] ra;
    logic [AW-1:0] addr;
    logic          halt_hit;
    logic          unused_ra_hi;

    assign ra           = RedirectAddr[AW-1:0];
    assign unused_ra_hi = ^RedirectAddr;

    // Stall re-issues the word already on ImemRdData so it stays stable; HALT freezes on it.
    always_comb begin
        addr = pc_q;
        if (state_q == S_HALT) begin
            addr = fpc_q;
        end else if (state_q == S_RUN) begin
            if (Redirect)   addr = ra;
            else if (Stall) addr = fpc_q;
        end
    end

    assign ImemRdAddr = 32'(addr);
    assign IfInstr    = ImemRdData;
    assign IfPc       = Rst ? 32'(RST_PC) : 32'(fpc_q);
    // Handshake: a word is consumed by decode on any cycle with IfValid=1 and Stall=0.
    assign IfValid    = fvld_q & ~Flush & (state_q != S_HALT) & ~Rst;
    assign Halted     = halted_q;
    assign DbgState   = state_q;

    assign halt_hit = (state_q == S_RUN) && fvld_q && (ImemRdData == HALT_WORD)
                      && !Redirect && !Flush;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            pc_q     <= RST_PC;
            fpc_q    <= RST_PC;
            fvld_q   <= 1'b0;
            halted_q <= 1'b0;
            state_q  <= S_WAIT;
        end else begin
            case (state_q)
                S_WAIT: begin
                    fpc_q   <= pc_q;
                    pc_q    <= pc_q + AW'(1);
                    fvld_q  <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    if (halt_hit) begin
                        state_q  <= S_HALT;
                        halted_q <= 1'b1;
                        fvld_q   <= 1'b0;
                    end else if (Redirect) begin
                        fpc_q  <= ra;
                        pc_q   <= ra + AW'(1);
                        fvld_q <= 1'b1;
                    end else if (!Stall) begin
                        fpc_q  <= pc_q;
                        pc_q   <= pc_q + AW'(1);
                        fvld_q <= 1'b1;
                    end
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
                default: begin
                    state_q <= S_WAIT;
                end
            endcase
        end
    end

`ifdef IFETCH_PERF_EN
    always_ff @(posedge Clk) begin
        if (Rst) begin
            FetchCount <= 32'd0;
            StallCount <= 32'd0;
        end else begin
            if (IfValid && !Stall && FetchCount != 32'hffffffff)
                FetchCount <= FetchCount + 32'd1;
            if (Stall && state_q == S_RUN && StallCount != 32'hffffffff)
                StallCount <= StallCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit with a registered 256-word memory model.
// Inputs change at negedge; outputs are sampled 1-3 time units later.
module tb_instruction_fetch_unit;
    localparam logic [31:0] HALT = 32'hffffffff;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] ImemRdAddr;
    logic [31:0] ImemRdData;
    logic        Stall;
    logic        Redirect;
    logic [31:0] RedirectAddr;
    logic        Flush;
    logic [31:0] IfPc;
    logic [31:0] IfInstr;
    logic        IfValid;
    logic        Halted;
    logic [1:0]  dbg_state;
`ifdef IFETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] StallCount;
`endif

    logic [31:0] mem [0:255];
    logic [63:0] exp_q [$];
    logic [63:0] mon_e;
    int          total = 0;
    int          passed = 0;
    bit          sb_on = 1'b0;

    instruction_fetch_unit dut (
        .Clk(Clk), .Rst(Rst), .ImemRdAddr(ImemRdAddr), .ImemRdData(ImemRdData),
        .Stall(Stall), .Redirect(Redirect), .RedirectAddr(RedirectAddr), .Flush(Flush),
        .IfPc(IfPc), .IfInstr(IfInstr), .IfValid(IfValid), .Halted(Halted),
`ifdef IFETCH_PERF_EN
        .FetchCount(FetchCount), .StallCount(StallCount),
`endif
        .DbgState(dbg_state)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) ImemRdData <= mem[ImemRdAddr[7:0]];

    function automatic logic [31:0] word_of(input int i);
        return 32'((i + 1) * 32'h11);
    endfunction

    task automatic push_pc(input int p);
        exp_q.push_back({32'(p), word_of(p)});
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic reset_dut();
        @(negedge Clk);
        sb_on = 1'b0;
        exp_q.delete();
        Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = 32'd0; Flush = 1'b0;
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
    endtask

    // Scoreboard: every consumed word (IfValid & ~Stall) must match the head of exp_q.
    always @(negedge Clk) begin
        #2;
        if (sb_on && IfValid && !Stall) begin
            total++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_unexpected: got pc=%h instr=%h, required no word", IfPc, IfInstr);
            end else begin
                mon_e = exp_q.pop_front();
                if ({IfPc, IfInstr} !== mon_e)
                    $display("FAIL sb_word: got pc=%h instr=%h, required pc=%h instr=%h",
                             IfPc, IfInstr, mon_e[63:32], mon_e[31:0]);
                else
                    passed++;
            end
        end
    end

    task automatic test_reset();
        @(negedge Clk);
        Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = 32'd0; Flush = 1'b0;
        @(negedge Clk); #1;
        total++;
        if ({IfValid, IfPc, Halted, ImemRdAddr} !== {1'b0, 32'd0, 1'b0, 32'd0})
            $display("FAIL reset_state: got v=%b pc=%h h=%b addr=%h, required 0/0/0/0",
                     IfValid, IfPc, Halted, ImemRdAddr);
        else passed++;
`ifdef IFETCH_PERF_EN
        total++;
        if ({FetchCount, StallCount} !== 64'd0)
            $display("FAIL reset_perf: got %0d/%0d, required 0/0", FetchCount, StallCount);
        else passed++;
`endif
        @(negedge Clk);
        Rst = 1'b0; #1;
        total++;
        if ({IfValid, ImemRdAddr} !== {1'b0, 32'd0})
            $display("FAIL wait_cycle: got v=%b addr=%h, required v=0 addr=0", IfValid, ImemRdAddr);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk); #1;
            total++;
            if ({IfValid, IfPc, IfInstr, ImemRdAddr} !== {1'b1, 32'(i), word_of(i), 32'(i + 1)})
                $display("FAIL first_words[%0d]: got v=%b pc=%h instr=%h addr=%h, required 1/%h/%h/%h",
                         i, IfValid, IfPc, IfInstr, ImemRdAddr, i, word_of(i), i + 1);
            else passed++;
        end
    endtask

    task automatic test_stall();
        reset_dut();
        sb_on = 1'b1;
        for (int i = 0; i < 5; i++) push_pc(i);
        tick(3);
        Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if ({IfValid, IfPc, IfInstr, ImemRdAddr} !== {1'b1, 32'd2, 32'h33, 32'd2})
                $display("FAIL stall_hold[%0d]: got v=%b pc=%h instr=%h addr=%h, required 1/2/33/2",
                         k, IfValid, IfPc, IfInstr, ImemRdAddr);
            else passed++;
            @(negedge Clk);
        end
        Stall = 1'b0;
`ifdef IFETCH_PERF_EN
        #1;
        total++;
        if ({FetchCount, StallCount} !== {32'd2, 32'd3})
            $display("FAIL stall_perf: got fetch=%0d stall=%0d, required 2/3", FetchCount, StallCount);
        else passed++;
`endif
        @(negedge Clk); #1;
        total++;
        if ({IfValid, IfPc} !== {1'b1, 32'd3})
            $display("FAIL stall_release: got v=%b pc=%h, required 1/3", IfValid, IfPc);
        else passed++;
        @(negedge Clk); #3;
        sb_on = 1'b0;
        total++;
        if (exp_q.size() != 0) $display("FAIL stall_drain: got %0d left, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_redirect();
        reset_dut();
        sb_on = 1'b1;
        for (int i = 0; i < 6; i++) push_pc(i);
        push_pc(32'h40); push_pc(32'h41);
        tick(6);
        Redirect = 1'b1; RedirectAddr = 32'h40; #1;
        total++;
        if ({IfValid, IfPc, ImemRdAddr} !== {1'b1, 32'd5, 32'h40})
            $display("FAIL redirect_slot: got v=%b pc=%h addr=%h, required 1/5/40", IfValid, IfPc, ImemRdAddr);
        else passed++;
        @(negedge Clk);
        Redirect = 1'b0; #1;
        total++;
        if ({IfValid, IfPc} !== {1'b1, 32'h40})
            $display("FAIL redirect_target: got v=%b pc=%h, required 1/40", IfValid, IfPc);
        else passed++;
        @(negedge Clk); #3;
        sb_on = 1'b0;
        total++;
        if (exp_q.size() != 0) $display("FAIL redirect_drain: got %0d left, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_redirect_stall_flush();
        reset_dut();
        sb_on = 1'b1;
        push_pc(0); push_pc(1); push_pc(32'h10); push_pc(32'h12); push_pc(32'h13);
        tick(3);
        Stall = 1'b1; Redirect = 1'b1; RedirectAddr = 32'h10;
        @(negedge Clk);
        Stall = 1'b0; Redirect = 1'b0; #1;
        total++;
        if ({IfValid, IfPc} !== {1'b1, 32'h10})
            $display("FAIL redir_stall: got v=%b pc=%h, required 1/10", IfValid, IfPc);
        else passed++;
        @(negedge Clk);
        Flush = 1'b1; #1;
        total++;
        if ({IfValid, IfPc} !== {1'b0, 32'h11})
            $display("FAIL flush_mask: got v=%b pc=%h, required 0/11", IfValid, IfPc);
        else passed++;
        @(negedge Clk);
        Flush = 1'b0; #1;
        total++;
        if ({IfValid, IfPc} !== {1'b1, 32'h12})
            $display("FAIL flush_after: got v=%b pc=%h, required 1/12", IfValid, IfPc);
        else passed++;
        @(negedge Clk); #3;
        sb_on = 1'b0;
        total++;
        if (exp_q.size() != 0) $display("FAIL rsf_drain: got %0d left, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_wrap();
        reset_dut();
        sb_on = 1'b1;
        push_pc(0); push_pc(32'hfe); push_pc(32'hff); push_pc(0); push_pc(1); push_pc(5); push_pc(6);
        tick(1);
        Redirect = 1'b1; RedirectAddr = 32'h3fe;
        @(negedge Clk);
        Redirect = 1'b0;
        @(negedge Clk); #1;
        total++;
        if ({IfPc, ImemRdAddr} !== {32'hff, 32'd0})
            $display("FAIL wrap_addr: got pc=%h addr=%h, required ff/0", IfPc, ImemRdAddr);
        else passed++;
        tick(2);
        Redirect = 1'b1; RedirectAddr = 32'h105;
        @(negedge Clk);
        Redirect = 1'b0; #1;
        total++;
        if ({IfValid, IfPc} !== {1'b1, 32'h5})
            $display("FAIL redirect_mask: got v=%b pc=%h, required 1/5", IfValid, IfPc);
        else passed++;
        @(negedge Clk); #3;
        sb_on = 1'b0;
        total++;
        if (exp_q.size() != 0) $display("FAIL wrap_drain: got %0d left, required 0", exp_q.size());
        else passed++;
    endtask

    task automatic test_halt();
        mem[7] = HALT;
        reset_dut();
        sb_on = 1'b1;
        for (int i = 0; i < 7; i++) push_pc(i);
        exp_q.push_back({32'd7, HALT});
        tick(8); #1;
        total++;
        if ({IfValid, IfInstr, Halted} !== {1'b1, HALT, 1'b0})
            $display("FAIL halt_word: got v=%b instr=%h h=%b, required 1/ffffffff/0", IfValid, IfInstr, Halted);
        else passed++;
        #2;
        sb_on = 1'b0;
        total++;
        if (exp_q.size() != 0) $display("FAIL halt_drain: got %0d left, required 0", exp_q.size());
        else passed++;
        @(negedge Clk);
        Redirect = 1'b1; RedirectAddr = 32'h20; Stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++;
            if ({IfValid, Halted, ImemRdAddr} !== {1'b0, 1'b1, 32'd7})
                $display("FAIL halted[%0d]: got v=%b h=%b addr=%h, required 0/1/7", k, IfValid, Halted, ImemRdAddr);
            else passed++;
            @(negedge Clk);
        end
`ifdef IFETCH_PERF_EN
        #1;
        total++;
        if ({FetchCount, StallCount} !== {32'd8, 32'd0})
            $display("FAIL halt_perf: got fetch=%0d stall=%0d, required 8/0", FetchCount, StallCount);
        else passed++;
`endif
        Redirect = 1'b0; Stall = 1'b0;
        mem[7] = word_of(7);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk); #1;
        total++;
        if ({IfValid, Halted, IfPc} !== {1'b0, 1'b0, 32'd0})
            $display("FAIL halt_reset: got v=%b h=%b pc=%h, required 0/0/0", IfValid, Halted, IfPc);
        else passed++;
        @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk); #1;
        total++;
        if ({IfValid, IfPc, IfInstr} !== {1'b1, 32'd0, 32'h11})
            $display("FAIL halt_recover: got v=%b pc=%h instr=%h, required 1/0/11", IfValid, IfPc, IfInstr);
        else passed++;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = word_of(i);
        Rst = 1'b1; Stall = 1'b0; Redirect = 1'b0; RedirectAddr = 32'd0; Flush = 1'b0;
        test_reset();
        test_stall();
        test_redirect();
        test_redirect_stall_flush();
        test_wrap();
        test_halt();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
